cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the two result producers: ALU/reservation station and load-store buffer.
- Each producer feeds a small per-source FIFO. A round-robin grant moves one result per cycle onto a registered broadcast.
- The broadcast drives the ROB result ports and the RS/LSB operand snoop ports.
- A speculative flush empties all queued results and the bus.

Parameters:
- DEPTH, 2, entries per source FIFO (power of two, ≥2)
- ROB_POS_W, 4, ROB index width (matches `ROB_POS_WID`)
- DATA_W, 32, result value width
- ADDR_W, 32, branch target width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous reset, active-high
- rdy  in  1  global ready; low = freeze all state
- rollback  in  1  flush request from ROB (misprediction)
- alu_push  in  1  ALU result valid
- alu_rob_pos  in  ROB_POS_W  destination ROB entry
- alu_val  in  DATA_W  result value
- alu_jump  in  1  branch taken outcome
- alu_pc  in  ADDR_W  redirect target
- alu_full  out  1  ALU FIFO holds DEPTH entries
- lsb_push  in  1  load result valid
- lsb_rob_pos  in  ROB_POS_W  destination ROB entry
- lsb_val  in  DATA_W  loaded value
- lsb_full  out  1  LSB FIFO holds DEPTH entries
- cdb_valid  out  1  broadcast valid this cycle
- cdb_src  out  1  0 = ALU, 1 = LSB
- cdb_rob_pos  out  ROB_POS_W  broadcast ROB index
- cdb_val  out  DATA_W  broadcast value
- cdb_jump  out  1  branch outcome (0 when cdb_src = 1)
- cdb_pc  out  ADDR_W  branch target (0 when cdb_src = 1)
- overflow  out  1  sticky error: push lost to a full FIFO

Behaviour:

Reset (rst = 1, asynchronous):
- Both FIFOs empty; rr_last = 1, so the ALU wins the first contention.
- All cdb_* outputs = 0; overflow = 0.
- alu_full = lsb_full = 0.

Rollback:
- Sampled on posedge. Priority over rdy and over everything except rst.
- Next cycle: both FIFOs empty, cdb_valid = 0, pushes in the rollback cycle discarded.
- rr_last and overflow are unchanged.

rdy = 0:
- FIFOs, rr_last, cdb_* and overflow all hold.
- Pushes are ignored and do not set overflow.

Head of each source (per cycle, rdy = 1, no rollback):
- If the FIFO is non-empty, the head is the FIFO front.
- If the FIFO is empty and push = 1, the head is the incoming data (bypass).
- Otherwise the source has no head.

Grant:
- Only one source has a head: grant that source.
- Both have heads: grant the source ≠ rr_last.
- rr_last updates only on a grant.

Output register:
- cdb_* <= the granted head, cdb_valid <= 1.
- No grant: cdb_valid <= 0 and other cdb_* fields hold their values.
- Latency: a push into an empty FIFO with no contention appears on cdb_valid the next cycle.

Push into a FIFO (when not consumed by bypass):
- Enqueue if count < DEPTH, or if the same FIFO is popped this cycle.
- Otherwise drop the push and set overflow = 1 (sticky until rst).

Full flags:
- alu_full / lsb_full = (count == DEPTH), from registered count only.
- Producers must not push while full.
- A push and a pop in the same cycle leave count unchanged.

FIFO mechanics:
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Count is log2(DEPTH)+1 bits.

Ordering:
- Per-source FIFO order is preserved.
- Cross-source order is not guaranteed.
- At most one broadcast per cycle.

LSB entries:
- cdb_jump and cdb_pc are driven as 0.

Decomposition:
- Use the shared macros.v: `ROB_POS_WID`, `DATA_WID`, `ADDR_WID`, and a new `CDB_SRC_ALU` = 0 / `CDB_SRC_LSB` = 1.
- Sub-module cdb_fifo: parameterised width and DEPTH, with push, pop, front, count, full, flush.
  - Instantiated twice: ALU payload width ROB_POS_W+DATA_W+1+ADDR_W; LSB payload width ROB_POS_W+DATA_W.
- Arbiter and output register stay in cdb_arbiter.

Test Plan:
1. Reset, then a single ALU push (pos = 3, val = 0x11, jump = 1, pc = 0x100) with both FIFOs empty -> next cycle cdb_valid = 1, src = 0, pos = 3, val = 0x11, jump = 1, pc = 0x100; following cycle cdb_valid = 0.
2. ALU (pos = 1) and LSB (pos = 2) push simultaneously for 3 cycles -> broadcasts alternate ALU1, LSB2, ALU1, LSB2, ALU1, LSB2; the first grant after reset goes to ALU; no overflow.
3. LSB pushes 3 entries (pos 4, 5, 6) while ALU pushes every cycle -> lsb_full rises when count reaches 2; all three LSB entries appear in order 4, 5, 6; a push attempted while full without a pop sets overflow = 1.
4. Two entries queued in each FIFO, rollback = 1 with a concurrent ALU push -> next cycle cdb_valid = 0 and both full flags 0; no stale pos appears afterwards; overflow unchanged.
5. rdy = 0 for 4 cycles with pending entries and pushes -> outputs and counts frozen; pushes lost without setting overflow; resume with rdy = 1 -> original order continues.
6. rst asserted asynchronously mid-cycle with entries queued -> outputs go to 0 immediately (before the next edge), FIFOs empty, overflow = 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared widths, source encodings and the round-robin pick helper for the
//   common data bus arbiter.
package cdb_arbiter_pkg;

    localparam int ROB_POS_WID = 4;
    localparam int DATA_WID    = 32;
    localparam int ADDR_WID    = 32;

    // cdb_src / rr_last encoding
    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LSB = 1'b1;

    // LSB wins when it is the only source with a head, or when both have
    // heads and the ALU was the most recent winner.
    function automatic logic pick_lsb(input logic alu_has,
                                      input logic lsb_has,
                                      input logic rr_last);
        return lsb_has & (~alu_has | (rr_last == CDB_SRC_ALU));
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo
//   Small per-source result queue with a synchronous flush.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     flush        drop every queued entry (wins over push/pop)
//     push, din    enqueue din (caller guarantees room or a same-cycle pop)
//     pop          dequeue the front entry
//     front        current front entry (valid when count != 0)
//     count        number of queued entries, 0..DEPTH
//     full         count == DEPTH
module cdb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               front,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);
    import cdb_arbiter_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush)
            r_mem[r_wp] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) r_wp <= r_wp + PW'(1);
            if (pop)  r_rp <= r_rp + PW'(1);
            if (push && !pop)
                r_cnt <= r_cnt + CW'(1);
            else if (pop && !push)
                r_cnt <= r_cnt - CW'(1);
        end
    end

    assign front = r_mem[r_rp];
    assign count = r_cnt;
    assign full  = (r_cnt == CW'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares the common data bus between the ALU and the load-store buffer.
//   Each producer feeds a cdb_fifo; an empty FIFO lets an incoming push
//   bypass straight to arbitration. A round-robin grant moves one result per
//   cycle into the registered broadcast.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     rdy                      low freezes all state, pushes ignored
//     rollback                 flush FIFOs and drop the broadcast valid
//     alu_push/rob_pos/val/jump/pc, alu_full   ALU producer side
//     lsb_push/rob_pos/val, lsb_full           LSB producer side
//     cdb_valid/src/rob_pos/val/jump/pc        registered broadcast
//     overflow                 sticky: a push was lost to a full FIFO
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int ROB_POS_W = ROB_POS_WID,
    parameter int DATA_W    = DATA_WID,
    parameter int ADDR_W    = ADDR_WID
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 alu_push,
    input  logic [ROB_POS_W-1:0] alu_rob_pos,
    input  logic [DATA_W-1:0]    alu_val,
    input  logic                 alu_jump,
    input  logic [ADDR_W-1:0]    alu_pc,
    output logic                 alu_full,
    input  logic                 lsb_push,
    input  logic [ROB_POS_W-1:0] lsb_rob_pos,
    input  logic [DATA_W-1:0]    lsb_val,
    output logic                 lsb_full,
    output logic                 cdb_valid,
    output logic                 cdb_src,
    output logic [ROB_POS_W-1:0] cdb_rob_pos,
    output logic [DATA_W-1:0]    cdb_val,
    output logic                 cdb_jump,
    output logic [ADDR_W-1:0]    cdb_pc,
    output logic                 overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = ROB_POS_W + DATA_W + 1 + ADDR_W;   // {pos, val, jump, pc}
    localparam int LW = ROB_POS_W + DATA_W;                // {pos, val}

    logic                 w_en;
    logic [AW-1:0]        w_alu_din, w_alu_front, w_alu_head;
    logic [LW-1:0]        w_lsb_din, w_lsb_front, w_lsb_head;
    logic [CW-1:0]        w_alu_cnt, w_lsb_cnt;
    logic                 w_alu_ne, w_lsb_ne;
    logic                 w_alu_has, w_lsb_has;
    logic                 w_pick_lsb, w_gnt_alu, w_gnt_lsb;
    logic                 w_alu_pop, w_lsb_pop;
    logic                 w_alu_req, w_lsb_req;
    logic                 w_alu_wr, w_lsb_wr;
    logic                 w_drop;

    logic                 r_rr_last;
    logic                 r_valid;
    logic                 r_src;
    logic [ROB_POS_W-1:0] r_pos;
    logic [DATA_W-1:0]    r_val;
    logic                 r_jump;
    logic [ADDR_W-1:0]    r_pc;
    logic                 r_overflow;

    // Rollback outranks rdy: no grant, no enqueue in a rollback cycle.
    assign w_en = rdy & ~rollback;

    assign w_alu_din = {alu_rob_pos, alu_val, alu_jump, alu_pc};
    assign w_lsb_din = {lsb_rob_pos, lsb_val};

    assign w_alu_ne = (w_alu_cnt != '0);
    assign w_lsb_ne = (w_lsb_cnt != '0);

    // Head is the FIFO front, or the incoming push when the FIFO is empty.
    assign w_alu_has  = w_alu_ne | alu_push;
    assign w_lsb_has  = w_lsb_ne | lsb_push;
    assign w_alu_head = w_alu_ne ? w_alu_front : w_alu_din;
    assign w_lsb_head = w_lsb_ne ? w_lsb_front : w_lsb_din;

    assign w_pick_lsb = pick_lsb(w_alu_has, w_lsb_has, r_rr_last);
    assign w_gnt_lsb  = w_en & w_pick_lsb;
    assign w_gnt_alu  = w_en & w_alu_has & ~w_pick_lsb;

    // A grant to a non-empty FIFO pops it; a grant to an empty one consumes
    // the push directly, so that push must not also be enqueued.
    assign w_alu_pop = w_gnt_alu & w_alu_ne;
    assign w_lsb_pop = w_gnt_lsb & w_lsb_ne;
    assign w_alu_req = w_en & alu_push & ~(w_gnt_alu & ~w_alu_ne);
    assign w_lsb_req = w_en & lsb_push & ~(w_gnt_lsb & ~w_lsb_ne);
    assign w_alu_wr  = w_alu_req & (~alu_full | w_alu_pop);
    assign w_lsb_wr  = w_lsb_req & (~lsb_full | w_lsb_pop);
    assign w_drop    = (w_alu_req & ~w_alu_wr) | (w_lsb_req & ~w_lsb_wr);

    cdb_fifo #(.W(AW), .DEPTH(DEPTH)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (rollback),
        .push  (w_alu_wr),
        .pop   (w_alu_pop),
        .din   (w_alu_din),
        .front (w_alu_front),
        .count (w_alu_cnt),
        .full  (alu_full)
    );

    cdb_fifo #(.W(LW), .DEPTH(DEPTH)) u_lsb_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (rollback),
        .push  (w_lsb_wr),
        .pop   (w_lsb_pop),
        .din   (w_lsb_din),
        .front (w_lsb_front),
        .count (w_lsb_cnt),
        .full  (lsb_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last  <= CDB_SRC_LSB;   // ALU wins the first contention
            r_valid    <= 1'b0;
            r_src      <= 1'b0;
            r_pos      <= '0;
            r_val      <= '0;
            r_jump     <= 1'b0;
            r_pc       <= '0;
            r_overflow <= 1'b0;
        end else if (rollback) begin
            r_valid <= 1'b0;
        end else if (rdy) begin
            if (w_gnt_alu) begin
                r_valid   <= 1'b1;
                r_src     <= CDB_SRC_ALU;
                r_pos     <= w_alu_head[AW-1 -: ROB_POS_W];
                r_val     <= w_alu_head[ADDR_W+DATA_W : ADDR_W+1];
                r_jump    <= w_alu_head[ADDR_W];
                r_pc      <= w_alu_head[ADDR_W-1:0];
                r_rr_last <= CDB_SRC_ALU;
            end else if (w_gnt_lsb) begin
                r_valid   <= 1'b1;
                r_src     <= CDB_SRC_LSB;
                r_pos     <= w_lsb_head[LW-1 -: ROB_POS_W];
                r_val     <= w_lsb_head[DATA_W-1:0];
                r_jump    <= 1'b0;
                r_pc      <= '0;
                r_rr_last <= CDB_SRC_LSB;
            end else begin
                r_valid <= 1'b0;
            end
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    assign cdb_valid   = r_valid;
    assign cdb_src     = r_src;
    assign cdb_rob_pos = r_pos;
    assign cdb_val     = r_val;
    assign cdb_jump    = r_jump;
    assign cdb_pc      = r_pc;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rdy = 1'b1, rollback = 1'b0;
  logic        alu_push = 1'b0, alu_jump = 1'b0, lsb_push = 1'b0;
  logic [3:0]  alu_rob_pos = '0, lsb_rob_pos = '0;
  logic [31:0] alu_val = '0, alu_pc = '0, lsb_val = '0;
  logic        alu_full, lsb_full, cdb_valid, cdb_src, cdb_jump, overflow;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_val, cdb_pc;

  cdb_arbiter #(.DEPTH(DEPTH), .ROB_POS_W(4), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_push(alu_push), .alu_rob_pos(alu_rob_pos), .alu_val(alu_val),
    .alu_jump(alu_jump), .alu_pc(alu_pc), .alu_full(alu_full),
    .lsb_push(lsb_push), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
    .lsb_full(lsb_full),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_pos(cdb_rob_pos),
    .cdb_val(cdb_val), .cdb_jump(cdb_jump), .cdb_pc(cdb_pc),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        src;
    logic [3:0]  pos;
    logic [31:0] val;
    logic        jump;
    logic [31:0] pc;
  } bc_t;

  bc_t alu_q[$], lsb_q[$], exp_q[$], obs_q[$];
  bc_t m_out;
  bit  m_valid, m_rr, m_ovf;
  int  errors = 0, checks = 0, seq = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    alu_q.delete(); lsb_q.delete(); exp_q.delete(); obs_q.delete();
    m_out = '0; m_valid = 0; m_rr = 1; m_ovf = 0;
  endtask

  // Drive one cycle, advance the reference model, compare after the edge.
  task automatic cyc_full(input bit ap, input logic [3:0] apos, input logic [31:0] aval,
                          input bit aj, input logic [31:0] apc,
                          input bit lp, input logic [3:0] lpos, input logic [31:0] lval);
    bc_t ai, li, e, o;
    bit  ah, lh, gl, ga, abyp, lbyp, upd;
    alu_push = ap; alu_rob_pos = apos; alu_val = aval; alu_jump = aj; alu_pc = apc;
    lsb_push = lp; lsb_rob_pos = lpos; lsb_val = lval;
    ai = '{src:1'b0, pos:apos, val:aval, jump:aj, pc:apc};
    li = '{src:1'b1, pos:lpos, val:lval, jump:1'b0, pc:32'h0};
    abyp = 0; lbyp = 0;
    upd = rdy && !rollback;
    if (rollback) begin
      alu_q.delete(); lsb_q.delete(); m_valid = 0;
    end else if (rdy) begin
      ah = (alu_q.size() > 0) || ap;
      lh = (lsb_q.size() > 0) || lp;
      gl = lh && (!ah || m_rr == 1'b0);
      ga = ah && !gl;
      if (ga) begin
        if (alu_q.size() > 0) e = alu_q.pop_front(); else begin e = ai; abyp = 1; end
        m_rr = 0; m_valid = 1; m_out = e; exp_q.push_back(e);
      end else if (gl) begin
        if (lsb_q.size() > 0) e = lsb_q.pop_front(); else begin e = li; lbyp = 1; end
        m_rr = 1; m_valid = 1; m_out = e; exp_q.push_back(e);
      end else m_valid = 0;
      if (ap && !abyp) begin if (alu_q.size() < DEPTH) alu_q.push_back(ai); else m_ovf = 1; end
      if (lp && !lbyp) begin if (lsb_q.size() < DEPTH) lsb_q.push_back(li); else m_ovf = 1; end
    end
    @(posedge clk); #1;
    chk("valid", cdb_valid, m_valid);
    chk("src", cdb_src, m_out.src);
    chk("pos", cdb_rob_pos, m_out.pos);
    chk("val", cdb_val, m_out.val);
    chk("jump", cdb_jump, m_out.jump);
    chk("pc", cdb_pc, m_out.pc);
    chk("alu_full", alu_full, alu_q.size() == DEPTH);
    chk("lsb_full", lsb_full, lsb_q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    if (upd && cdb_valid) begin
      o = '{src:cdb_src, pos:cdb_rob_pos, val:cdb_val, jump:cdb_jump, pc:cdb_pc};
      obs_q.push_back(o);
      chk("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_src", o.src, e.src);
        chk("sb_pos", o.pos, e.pos);
        chk("sb_val", o.val, e.val);
        chk("sb_jump", o.jump, e.jump);
        chk("sb_pc", o.pc, e.pc);
      end
    end
  endtask

  task automatic cyc(input bit ap, input logic [3:0] apos, input bit lp, input logic [3:0] lpos);
    logic [31:0] s;
    seq++;
    s = seq;
    cyc_full(ap, apos, 32'hA000_0000 | s, s[0], 32'h1000 + (s << 2),
             lp, lpos, 32'hB000_0000 | s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 4'h0, 0, 4'h0);
  endtask

  task automatic do_reset();
    rst = 1; rdy = 1; rollback = 0; alu_push = 0; lsb_push = 0;
    @(posedge clk); #1;
    model_reset();
    chk("rst_valid", cdb_valid, 0);
    chk("rst_pos", cdb_rob_pos, 0);
    chk("rst_val", cdb_val, 0);
    chk("rst_pc", cdb_pc, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_full", {alu_full, lsb_full}, 2'b00);
    rst = 0;
  endtask

  logic       sv_valid, sv_src;
  logic [3:0] sv_pos;
  int         base, k;

  initial begin
    // 1: single ALU push, one-cycle latency
    do_reset();
    cyc_full(1, 4'd3, 32'h11, 1, 32'h100, 0, 4'd0, 32'h0);
    chk("t1_valid", cdb_valid, 1);
    chk("t1_src", cdb_src, 0);
    chk("t1_pos", cdb_rob_pos, 3);
    chk("t1_val", cdb_val, 32'h11);
    chk("t1_jump", cdb_jump, 1);
    chk("t1_pc", cdb_pc, 32'h100);
    idle(1);
    chk("t1_idle", cdb_valid, 0);

    // 2: simultaneous pushes alternate, ALU first
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 4'd1, 1, 4'd2);
    idle(4);
    chk("t2_count", obs_q.size(), 6);
    for (int i = 0; i < obs_q.size(); i++) begin
      chk("t2_src", obs_q[i].src, i % 2);
      chk("t2_pos", obs_q[i].pos, (i % 2) ? 2 : 1);
    end
    chk("t2_ovf", overflow, 0);

    // 3: LSB fills while ALU pushes every cycle; ALU eventually overflows
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1, 4'(8 + i), i < 3, 4'(4 + i));
      if (i == 1) chk("t3_lsb_notfull", lsb_full, 0);
      if (i == 2) begin
        chk("t3_lsb_full", lsb_full, 1);
        chk("t3_ovf_clear", overflow, 0);
      end
    end
    chk("t3_ovf_set", overflow, 1);
    idle(6);
    k = 0;
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i].src) begin
        chk("t3_lsb_order", obs_q[i].pos, 4 + k);
        k++;
      end
    chk("t3_lsb_seen", k, 3);

    // 5: rdy low freezes everything
    do_reset();
    cyc(1, 4'd1, 1, 4'd2);
    cyc(1, 4'd3, 1, 4'd4);
    sv_valid = cdb_valid; sv_src = cdb_src; sv_pos = cdb_rob_pos;
    chk("t5_snap", {sv_valid, sv_src, sv_pos}, {1'b1, 1'b1, 4'd2});
    rdy = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4'd9, 1, 4'd10);
      chk("t5_hold", {cdb_valid, cdb_src, cdb_rob_pos}, {sv_valid, sv_src, sv_pos});
      chk("t5_ovf", overflow, 0);
    end
    rdy = 1;
    base = obs_q.size();
    idle(4);
    chk("t5_resume_n", obs_q.size() - base, 2);
    if (obs_q.size() - base == 2) begin
      chk("t5_resume0", {obs_q[base].src, obs_q[base].pos}, {1'b0, 4'd3});
      chk("t5_resume1", {obs_q[base+1].src, obs_q[base+1].pos}, {1'b1, 4'd4});
    end

    // 4: rollback with both FIFOs full and overflow already set
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 4'(1 + i), 1, 4'(9 + i));
    chk("t4_ovf_pre", overflow, 1);
    rollback = 1;
    cyc(1, 4'hF, 0, 4'h0);
    rollback = 0;
    chk("t4_valid", cdb_valid, 0);
    chk("t4_full", {alu_full, lsb_full}, 2'b00);
    chk("t4_ovf_kept", overflow, 1);
    base = obs_q.size();
    idle(3);
    chk("t4_no_stale", obs_q.size(), base);
    cyc(1, 4'd2, 1, 4'd3);
    chk("t4_rr_kept", {cdb_valid, cdb_src, cdb_rob_pos}, {1'b1, 1'b1, 4'd3});
    cyc(1, 4'd6, 1, 4'd7);

    // 6: asynchronous reset mid-cycle
    #3 rst = 1;
    #1;
    chk("t6_valid", cdb_valid, 0);
    chk("t6_pos", cdb_rob_pos, 0);
    chk("t6_val", cdb_val, 0);
    chk("t6_src", cdb_src, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_full", {alu_full, lsb_full}, 2'b00);
    alu_push = 0; lsb_push = 0;
    @(posedge clk); #1;
    model_reset();
    rst = 0;
    idle(3);

    chk("end_sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
